// File: rtl/nios_pio_pkg.sv
// rtl/nios_pio_pkg.sv - register map and edge-type encodings for the input PIO
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_debounce.sv
// rtl/pio_debounce.sv - single-bit debounce filter; dout follows din only after
// din has differed from dout for DEBOUNCE_CYCLES consecutive cycles
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      dout <= din;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nios_pio_in_edge.sv
// rtl/nios_pio_in_edge.sv - Avalon-MM input PIO with sticky edge capture and masked irq
// Optional per-bit debounce filter compiled in with PIO_IN_DEBOUNCE_EN.
module nios_pio_in_edge
  import nios_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (sync_q[SYNC_STAGES-1][g]),
      .dout   (data_in[g])
    );
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign data_in = sync_q[SYNC_STAGES-1];
`endif

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_det = ~data_in & data_d;
      EDGE_ANY:  edge_det = data_in ^ data_d;
      default:   edge_det = data_in & ~data_d;
    endcase
  end

  assign wr_en    = chipselect && !write_n;
  assign clr_mask = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = data_in;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      default:      rd_next = '0;
    endcase
  end

  // A new edge beats a same-cycle clear so no event is ever dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_d   <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
    end else begin
      data_d   <= data_in;
      edgecap  <= (edgecap & ~clr_mask) | edge_det;
      readdata <= rd_next;
      if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_pio_in_edge.sv
// tb/tb_nios_pio_in_edge.sv - directed bench for three edge-type builds of nios_pio_in_edge
module tb_nios_pio_in_edge;

  localparam int W  = 8;
  localparam int SS = 2;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = SS + DB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] ip0, ip1, ip2;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  logic [31:0] v;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nios_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(ip0), .readdata(rd0), .irq(irq0));
  nios_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(ip1), .readdata(rd1), .irq(irq1));
  nios_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(ip2), .readdata(rd2), .irq(irq2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd(input int sel, input logic [1:0] a, output logic [31:0] val);
    address = a;
    @(posedge clk);
    @(negedge clk);
    val = (sel == 0) ? rd0 : (sel == 1) ? rd1 : rd2;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    ip0 = '0; ip1 = '0; ip2 = '0;
    @(negedge clk);
    ip0 = 8'hFF; ip1 = 8'h3C; ip2 = 8'h01;
    cycles(2);
    ip0 = 8'h00; ip1 = 8'h00; ip2 = 8'h00;
    cycles(2);
    check("reset_readdata", rd0, 32'h0);
    check("reset_irq", {31'd0, irq0}, 32'h0);
    reset_n = 1'b1;
    cycles(LAT + 3);
    rd(0, 2'd0, v); check("post_reset_data", v, 32'h0);
    rd(0, 2'd1, v); check("post_reset_resv", v, 32'h0);
    rd(0, 2'd2, v); check("post_reset_mask", v, 32'h0);
    rd(0, 2'd3, v); check("post_reset_edgecap", v, 32'h0);

    // rising-edge build
    ip0 = 8'hA5; ip1 = 8'hFF;
    cycles(LAT + 2);
    rd(0, 2'd0, v); check("rise_data", v, 32'hA5);
    rd(0, 2'd3, v); check("rise_edgecap", v, 32'hA5);
    check("rise_irq_unmasked", {31'd0, irq0}, 32'h0);
    rd(1, 2'd3, v); check("fall_no_rise_capture", v, 32'h0);
    wr(2'd2, 32'h01);
    check("irq_masked_in", {31'd0, irq0}, 32'h1);
    rd(0, 2'd2, v); check("mask_readback", v, 32'h01);
    wr(2'd3, 32'h01);
    check("irq_after_clear", {31'd0, irq0}, 32'h0);
    rd(0, 2'd3, v); check("edgecap_after_clear", v, 32'hA4);
    wr(2'd2, 32'h100);
    rd(0, 2'd2, v); check("mask_upper_ignored", v, 32'h0);
    wr(2'd1, 32'hFF);
    rd(0, 2'd1, v); check("reserved_reads_zero", v, 32'h0);

    // falling-edge build
    ip1 = 8'h0F;
    cycles(LAT + 2);
    rd(1, 2'd3, v); check("fall_edgecap", v, 32'hF0);
    rd(1, 2'd0, v); check("fall_data", v, 32'h0F);

    // any-edge build: bit 0 captured on both transitions
    ip2 = 8'h01;
    cycles(LAT + 2);
    rd(2, 2'd3, v); check("any_rise_edgecap", v, 32'h01);
    wr(2'd3, 32'h01);
    rd(2, 2'd3, v); check("any_cleared", v, 32'h00);
    ip2 = 8'h00;
    cycles(LAT + 2);
    rd(2, 2'd3, v); check("any_fall_edgecap", v, 32'h01);

    // edge on bit 3 lands on the same edge as a write-1-clear of bit 3
    wr(2'd3, 32'hFF);
    rd(0, 2'd3, v); check("all_cleared", v, 32'h0);
    ip0 = 8'hAD;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    wr(2'd3, 32'h08);
    rd(0, 2'd3, v); check("set_wins_over_clear", v, 32'h08);
    wr(2'd2, 32'h08);
    check("irq_bit3", {31'd0, irq0}, 32'h1);
    wr(2'd3, 32'h08);
    check("irq_bit3_cleared", {31'd0, irq0}, 32'h0);

`ifdef PIO_IN_DEBOUNCE_EN
    ip0 = 8'hED;
    cycles(5);
    ip0 = 8'hAD;
    cycles(30);
    rd(0, 2'd0, v); check("db_pulse_data", v, 32'hAD);
    rd(0, 2'd3, v); check("db_pulse_edgecap", v, 32'h0);
    ip0 = 8'hED;
    cycles(SS + 16 - 3);
    rd(0, 2'd0, v); check("db_level_early", v, 32'hAD);
    cycles(4);
    rd(0, 2'd0, v); check("db_level_data", v, 32'hED);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
